// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared definitions for the SPI arbiter.
//   - one-hot FSM state encodings
//   - bit offsets of the 11-bit engine config word {ratio, mode, store}
//   - byte counter width (9 bits so that a 256-byte burst never wraps)
//   - pack_cfg(): turns a requester's 10-bit {ratio, mode} into an engine config write
package spi_arb_pkg;

    typedef logic [6:0] state_t;

    localparam state_t S_IDLE      = 7'b0000001;
    localparam state_t S_CONFIG    = 7'b0000010;
    localparam state_t S_CFG_WAIT  = 7'b0000100;
    localparam state_t S_CS_SETUP  = 7'b0001000;
    localparam state_t S_SEND      = 7'b0010000;
    localparam state_t S_WAIT_BYTE = 7'b0100000;
    localparam state_t S_CS_HOLD   = 7'b1000000;

    localparam int CFG_W        = 10;  // requester {ratio[9:2], mode[1:0]}
    localparam int SPI_CFG_W    = 11;  // engine {ratio, mode, store}
    localparam int CFG_STORE    = 0;
    localparam int CFG_MODE_LO  = 1;
    localparam int CFG_MODE_HI  = 2;
    localparam int CFG_RATIO_LO = 3;
    localparam int CFG_RATIO_HI = 10;

    localparam int BCNT_W = 9;

    function automatic logic [SPI_CFG_W-1:0] pack_cfg(input logic [CFG_W-1:0] c);
        logic [SPI_CFG_W-1:0] v;
        v                             = '0;
        v[CFG_STORE]                  = 1'b1;
        v[CFG_MODE_HI:CFG_MODE_LO]    = c[1:0];
        v[CFG_RATIO_HI:CFG_RATIO_LO]  = c[9:2];
        return v;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr.sv
// rr_arbiter: round-robin request picker.
//   i_clk, i_rst : clock, synchronous active-high reset (pointer -> 0)
//   i_req        : N-wide request vector
//   i_update     : advance pointer to winner+1 (mod N) this cycle
//   o_grant      : one-hot winner (combinational)
//   o_win        : winner index
//   o_any        : at least one request present
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_update,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_win,
    output logic          o_any
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_next_ptr;
    int            w_idx;

    // Search starts at the pointer; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_win   = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_win          = IW'(w_idx);
                o_grant[w_idx] = 1'b1;
            end
        end
    end

    assign w_next_ptr = (o_win == IW'(N - 1)) ? '0 : o_win + IW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ptr <= '0;
        else if (i_update && o_any)
            r_ptr <= w_next_ptr;
    end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI byte engine between N_REQ requesters.
// Per grant: loads the winner's config into the engine, drops its chip
// select, streams i_len+1 bytes and returns each received byte to the owner.
//   Requester side : i_req, i_len, i_cfg, i_tx, i_tx_valid -> o_tx_pop,
//                    o_grant, o_rx, o_rx_valid, o_done, o_cs_n
//   Engine side    : o_spi_config, o_spi_tx, o_spi_tx_valid <- i_spi_rx,
//                    i_spi_rx_valid, i_spi_ready
// Optional build macro SPI_ARB_CFG_CACHE_EN: remembers the last config written
// and skips the config step when the next winner's config matches it.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [8*N_REQ-1:0]     i_len,
    input  logic [10*N_REQ-1:0]    i_cfg,
    input  logic [8*N_REQ-1:0]     i_tx,
    input  logic [N_REQ-1:0]       i_tx_valid,
    output logic [N_REQ-1:0]       o_tx_pop,
    output logic [N_REQ-1:0]       o_grant,
    output logic [7:0]             o_rx,
    output logic [N_REQ-1:0]       o_rx_valid,
    output logic [N_REQ-1:0]       o_done,
    output logic [N_REQ-1:0]       o_cs_n,
    output logic [SPI_CFG_W-1:0]   o_spi_config,
    output logic [7:0]             o_spi_tx,
    output logic                   o_spi_tx_valid,
    input  logic [7:0]             i_spi_rx,
    input  logic                   i_spi_rx_valid,
    input  logic                   i_spi_ready
);

    localparam int IW   = $clog2(N_REQ);
    localparam int TMAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    state_t             r_state, w_next;
    logic [IW-1:0]      r_win, w_arb_win;
    logic [N_REQ-1:0]   r_win_oh, w_arb_gnt;
    logic               w_arb_any, w_arb_en, w_win, w_cache_hit, w_tx_fire, w_last;
    logic [7:0]         r_len;
    logic [CFG_W-1:0]   r_cfg, w_arb_cfg;
    logic [BCNT_W-1:0]  r_byte;
    logic [TW-1:0]      r_tmr;
    logic [7:0]         r_rx;
    logic [N_REQ-1:0]   r_rx_valid, r_done;

    // No arbitration in the o_done cycle: the finishing requester still holds
    // i_req there and would otherwise be re-granted before it can react.
    assign w_arb_en  = (r_state == S_IDLE) && i_spi_ready && (r_done == '0);
    assign w_win     = w_arb_en && w_arb_any;
    assign w_arb_cfg = i_cfg[w_arb_win*CFG_W +: CFG_W];
    assign w_tx_fire = (r_state == S_SEND) && i_tx_valid[r_win] && i_spi_ready;
    assign w_last    = (r_byte == {1'b0, r_len});

    rr_arbiter #(.N(N_REQ)) u_rr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (i_req),
        .i_update (w_win),
        .o_grant  (w_arb_gnt),
        .o_win    (w_arb_win),
        .o_any    (w_arb_any)
    );

`ifdef SPI_ARB_CFG_CACHE_EN
    logic [CFG_W-1:0] r_cache;
    logic             r_cache_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cache     <= '0;
            r_cache_vld <= 1'b0;
        end else if (r_state == S_CONFIG) begin
            r_cache     <= r_cfg;
            r_cache_vld <= 1'b1;
        end
    end

    assign w_cache_hit = r_cache_vld && (r_cache == w_arb_cfg);
`else
    assign w_cache_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_win) w_next = w_cache_hit ? S_CS_SETUP : S_CONFIG;
            S_CONFIG:    w_next = S_CFG_WAIT;
            S_CFG_WAIT:  if (i_spi_ready) w_next = S_CS_SETUP;
            S_CS_SETUP:  if (r_tmr == TW'(CS_SETUP_CYC - 1)) w_next = S_SEND;
            S_SEND:      if (w_tx_fire) w_next = S_WAIT_BYTE;
            S_WAIT_BYTE: if (i_spi_rx_valid) w_next = w_last ? S_CS_HOLD : S_SEND;
            S_CS_HOLD:   if (r_tmr == TW'(CS_HOLD_CYC - 1)) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_grant        = '0;
        o_cs_n         = '1;
        o_spi_config   = '0;
        o_spi_tx       = '0;
        o_spi_tx_valid = 1'b0;
        o_tx_pop       = '0;
        case (r_state)
            S_CONFIG: begin
                o_grant      = r_win_oh;
                o_spi_config = pack_cfg(r_cfg);
            end
            S_CFG_WAIT: o_grant = r_win_oh;
            S_CS_SETUP, S_WAIT_BYTE, S_CS_HOLD: begin
                o_grant = r_win_oh;
                o_cs_n  = ~r_win_oh;
            end
            S_SEND: begin
                o_grant = r_win_oh;
                o_cs_n  = ~r_win_oh;
                if (w_tx_fire) begin
                    o_spi_tx       = i_tx[r_win*8 +: 8];
                    o_spi_tx_valid = 1'b1;
                    o_tx_pop       = r_win_oh;
                end
            end
            default: ;
        endcase
    end

    // Phase timer for CS setup/hold; restarts on every state change.
    always_ff @(posedge i_clk) begin
        if (i_rst)                 r_tmr <= '0;
        else if (r_state != w_next) r_tmr <= '0;
        else                       r_tmr <= r_tmr + TW'(1);
    end

    // Datapath: winner latch, byte counter, registered rx/done pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_win      <= '0;
            r_win_oh   <= '0;
            r_len      <= '0;
            r_cfg      <= '0;
            r_byte     <= '0;
            r_rx       <= '0;
            r_rx_valid <= '0;
            r_done     <= '0;
        end else begin
            r_rx_valid <= '0;
            r_done     <= '0;
            if (w_win) begin
                r_win    <= w_arb_win;
                r_win_oh <= w_arb_gnt;
                r_len    <= i_len[w_arb_win*8 +: 8];
                r_cfg    <= w_arb_cfg;
                r_byte   <= '0;
            end
            // rx_valid is only honoured mid-burst; a stale one after reset is dropped.
            if (r_state == S_WAIT_BYTE && i_spi_rx_valid) begin
                r_rx       <= i_spi_rx;
                r_rx_valid <= r_win_oh;
                if (!w_last) r_byte <= r_byte + BCNT_W'(1);
            end
            if (r_state == S_CS_HOLD && w_next == S_IDLE)
                r_done <= r_win_oh;
        end
    end

    assign o_rx       = r_rx;
    assign o_rx_valid = r_rx_valid;
    assign o_done     = r_done;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed bench for spi_arbiter with a small engine model
// (config write = 3 busy cycles, byte = 4 busy cycles, rx echoes tx).
module tb_spi_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req      = '0;
    logic [N-1:0]    tx_valid = '0;
    logic [8*N-1:0]  len_bus  = '0;
    logic [10*N-1:0] cfg_bus  = '0;
    logic [8*N-1:0]  tx_bus;

    logic [N-1:0]  tx_pop, grant, rx_valid, done, cs_n;
    logic [7:0]    rx, spi_tx;
    logic [10:0]   spi_cfg;
    logic          spi_tx_valid;

    // engine model
    logic       e_ready = 1'b1;
    logic       e_rxv   = 1'b0;
    logic [7:0] e_rx    = '0;
    logic [7:0] e_data  = '0;
    logic       e_pend  = 1'b0;
    int         e_cnt   = 0;

    // requester tx data tables, advanced by o_tx_pop
    logic [7:0] tx_tab [N][64];
    logic [5:0] pop_cnt [N];

    spi_arbiter #(.N_REQ(N), .CS_SETUP_CYC(2), .CS_HOLD_CYC(2)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_len          (len_bus),
        .i_cfg          (cfg_bus),
        .i_tx           (tx_bus),
        .i_tx_valid     (tx_valid),
        .o_tx_pop       (tx_pop),
        .o_grant        (grant),
        .o_rx           (rx),
        .o_rx_valid     (rx_valid),
        .o_done         (done),
        .o_cs_n         (cs_n),
        .o_spi_config   (spi_cfg),
        .o_spi_tx       (spi_tx),
        .o_spi_tx_valid (spi_tx_valid),
        .i_spi_rx       (e_rx),
        .i_spi_rx_valid (e_rxv),
        .i_spi_ready    (e_ready)
    );

    for (genvar g = 0; g < N; g++) begin : g_tx
        assign tx_bus[g*8 +: 8] = tx_tab[g][pop_cnt[g]];
    end

    initial begin
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 64; k++) tx_tab[i][k] = 8'h00;
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (tx_pop[i]) pop_cnt[i] <= pop_cnt[i] + 6'd1;
    end
    initial for (int i = 0; i < N; i++) pop_cnt[i] = '0;

    always @(posedge clk) begin
        e_rxv <= 1'b0;
        if (e_ready && spi_tx_valid) begin
            e_ready <= 1'b0; e_cnt <= 3; e_data <= spi_tx; e_pend <= 1'b1;
        end else if (e_ready && spi_cfg[0]) begin
            e_ready <= 1'b0; e_cnt <= 2; e_pend <= 1'b0;
        end else if (!e_ready) begin
            if (e_cnt == 0) begin
                e_ready <= 1'b1; e_rxv <= e_pend; e_rx <= e_data;
            end else e_cnt <= e_cnt - 1;
        end
    end

    // ---------------- monitor ----------------
    function automatic int oh2i(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    int n_cfg = 0, n_cfg_busy = 0, n_cfg_wide = 0, n_overlap = 0, n_txv = 0;
    int n_rxv [N];
    int n_done [N];
    int cfg_q [$];
    int rx_log [$];
    int grant_log [$];
    logic [N-1:0] prev_gnt = '0;
    logic prev_store = 1'b0, prev_low = 1'b0, started = 1'b0;
    int setup_cnt = 0, hold_cnt = 0, last_setup = -1, last_hold = -1;

    initial for (int i = 0; i < N; i++) begin n_rxv[i] = 0; n_done[i] = 0; end

    always @(negedge clk) begin
        prev_gnt   <= grant;
        prev_store <= spi_cfg[0];
        prev_low   <= ~&cs_n;
        if (grant != '0 && grant != prev_gnt) grant_log.push_back(oh2i(grant));
        if (spi_cfg[0]) begin
            n_cfg <= n_cfg + 1;
            cfg_q.push_back(int'(spi_cfg));
            if (!e_ready)   n_cfg_busy <= n_cfg_busy + 1;
            if (prev_store) n_cfg_wide <= n_cfg_wide + 1;
            if (spi_tx_valid) n_overlap <= n_overlap + 1;
        end
        if (spi_tx_valid) n_txv <= n_txv + 1;
        if (rx_valid != '0) rx_log.push_back((oh2i(rx_valid) << 8) | int'(rx));
        for (int i = 0; i < N; i++) begin
            if (rx_valid[i]) n_rxv[i]  <= n_rxv[i] + 1;
            if (done[i])     n_done[i] <= n_done[i] + 1;
        end
        if (~&cs_n) begin
            if (!started) begin
                if (spi_tx_valid) begin started <= 1'b1; last_setup <= setup_cnt; end
                else setup_cnt <= setup_cnt + 1;
            end
            if (e_rxv) hold_cnt <= 0; else hold_cnt <= hold_cnt + 1;
        end else begin
            setup_cnt <= 0;
            started   <= 1'b0;
            if (prev_low) last_hold <= hold_cnt;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_valid = '1;
        repeat (2) @(negedge clk);
    endtask

    task automatic load(input int r, input int k, input logic [7:0] b);
        tx_tab[r][6'(int'(pop_cnt[r]) + k)] = b;
    endtask

    task automatic wait_done(input int r);
        int t;
        t = 0;
        while (!done[r] && t < 3000) begin @(negedge clk); t++; end
        if (!done[r]) chk($sformatf("done_timeout_%0d", r), int'(done[r]), 1);
    endtask

    task automatic wait_pops(input int r, input int n);
        logic [5:0] base;
        int t;
        base = pop_cnt[r];
        t = 0;
        while (int'(6'(pop_cnt[r] - base)) < n && t < 2000) begin @(negedge clk); t++; end
        if (int'(6'(pop_cnt[r] - base)) < n) chk("pop_timeout", int'(6'(pop_cnt[r] - base)), n);
    endtask

    task automatic serve(input int r, input logic [7:0] len, input logic [9:0] cfg);
        len_bus[r*8 +: 8]  = len;
        cfg_bus[r*10 +: 10] = cfg;
        req[r] = 1'b1;
        wait_done(r);
        req[r] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int b_cfg, b_rx, b_txv, b_rxv, b_done, b_gnt, t, stall_tx, stall_cs;
        int exp_cfgs;

        // ---- reset state ----
        do_reset();
        chk("rst_cs_n",     int'(cs_n), 'hF);
        chk("rst_grant",    int'(grant), 0);
        chk("rst_done",     int'(done), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_tx_valid", int'(spi_tx_valid), 0);
        chk("rst_config",   int'(spi_cfg), 0);
        chk("rst_rx",       int'(rx), 0);

        // ---- single requester, 3 bytes, cfg {ratio 2, mode 1} ----
        load(0, 0, 8'hA5); load(0, 1, 8'h3C); load(0, 2, 8'hFF);
        b_cfg = n_cfg; b_rx = rx_log.size(); b_txv = n_txv; b_rxv = n_rxv[0]; b_done = n_done[0];
        serve(0, 8'd2, 10'h009);
        chk("single_cfg_count", n_cfg - b_cfg, 1);
        chk("single_cfg_value", cfg_q[cfg_q.size()-1], 'h013);
        chk("single_tx_count",  n_txv - b_txv, 3);
        chk("single_rxv_count", n_rxv[0] - b_rxv, 3);
        chk("single_rx0", rx_log[b_rx],   'h0A5);
        chk("single_rx1", rx_log[b_rx+1], 'h03C);
        chk("single_rx2", rx_log[b_rx+2], 'h0FF);
        chk("single_done", n_done[0] - b_done, 1);
        chk("single_setup", last_setup, 2);
        chk("single_hold",  last_hold, 2);

        // ---- fairness: all four requesting, 1-byte bursts ----
        do_reset();
        len_bus = '0;
        for (int i = 0; i < N; i++) cfg_bus[i*10 +: 10] = 10'h009;
        b_gnt = grant_log.size();
        req = '1;
        t = 0;
        while (grant_log.size() < b_gnt + 5 && t < 3000) begin @(negedge clk); t++; end
        req = '0;
        chk("fair_grants", grant_log.size() - b_gnt, 5);
        if (grant_log.size() >= b_gnt + 5) begin
            chk("fair_g0", grant_log[b_gnt],   0);
            chk("fair_g1", grant_log[b_gnt+1], 1);
            chk("fair_g2", grant_log[b_gnt+2], 2);
            chk("fair_g3", grant_log[b_gnt+3], 3);
            chk("fair_g4", grant_log[b_gnt+4], 0);
        end
        wait_done(0);
        repeat (4) @(negedge clk);

        // ---- tx stall before byte 2 ----
        do_reset();
        load(0, 0, 8'h11); load(0, 1, 8'h22); load(0, 2, 8'h33); load(0, 3, 8'h44);
        b_rx = rx_log.size(); b_rxv = n_rxv[0];
        len_bus[7:0] = 8'd3; cfg_bus[9:0] = 10'h009;
        req[0] = 1'b1;
        wait_pops(0, 2);
        tx_valid[0] = 1'b0;
        stall_tx = 0; stall_cs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (spi_tx_valid) stall_tx++;
            if (!cs_n[0])     stall_cs++;
        end
        tx_valid[0] = 1'b1;
        chk("stall_no_tx", stall_tx, 0);
        chk("stall_cs_low", stall_cs, 10);
        wait_done(0);
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_rxv_count", n_rxv[0] - b_rxv, 4);
        chk("stall_rx0", rx_log[b_rx],   'h011);
        chk("stall_rx1", rx_log[b_rx+1], 'h022);
        chk("stall_rx2", rx_log[b_rx+2], 'h033);
        chk("stall_rx3", rx_log[b_rx+3], 'h044);

        // ---- config change between requesters ----
        do_reset();
        b_cfg = n_cfg;
        serve(1, 8'd0, 10'h013);   // ratio 4, mode 3
        serve(2, 8'd0, 10'h020);   // ratio 8, mode 0
        chk("cfgchg_count", n_cfg - b_cfg, 2);
        chk("cfgchg_first",  cfg_q[cfg_q.size()-2], 'h027);
        chk("cfgchg_second", cfg_q[cfg_q.size()-1], 'h041);

        // ---- reset mid-burst at byte 1 of 4 ----
        do_reset();
        len_bus[3*8 +: 8] = 8'd3; cfg_bus[3*10 +: 10] = 10'h009;
        req[3] = 1'b1;
        wait_pops(3, 2);
        b_rxv = n_rxv[3]; b_done = n_done[3];
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("midrst_cs_n",  int'(cs_n), 'hF);
        chk("midrst_grant", int'(grant), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", n_done[3] - b_done, 0);
        chk("midrst_no_rxv",  n_rxv[3] - b_rxv, 0);
        load(2, 0, 8'h5A); load(2, 1, 8'hC3);
        b_rx = rx_log.size(); b_done = n_done[2];
        serve(2, 8'd1, 10'h020);
        chk("after_rst_done", n_done[2] - b_done, 1);
        chk("after_rst_rx0", rx_log[b_rx],   'h25A);
        chk("after_rst_rx1", rx_log[b_rx+1], 'h2C3);

        // ---- same requester twice with identical config ----
        do_reset();
        b_cfg = n_cfg;
        serve(0, 8'd0, 10'h009);
        serve(0, 8'd0, 10'h009);
`ifdef SPI_ARB_CFG_CACHE_EN
        exp_cfgs = 1;
`else
        exp_cfgs = 2;
`endif
        chk("repeat_cfg_count", n_cfg - b_cfg, exp_cfgs);

        // ---- global protocol properties ----
        chk("cfg_while_busy",    n_cfg_busy, 0);
        chk("cfg_pulse_wide",    n_cfg_wide, 0);
        chk("cfg_tx_overlap",    n_overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
